// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and types for the register-file write path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic [1:0] {
        SRC_NONE      = 2'd0,
        SRC_WB        = 2'd1,
        SRC_MD_FIFO   = 2'd2,
        SRC_MD_BYPASS = 2'd3
    } rf_src_e;

endpackage

`default_nettype wire

// File: rtl/md_result_fifo.sv
// ============================================================================
// Module   : md_result_fifo
// Purpose  : Small strict-order buffer for multiply/divide results awaiting the
//            register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_result_fifo #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full      = (r_count == C_DEPTH);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_addr = r_addr_mem[r_rd_ptr];
    assign o_head_data = r_data_mem[r_rd_ptr];

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_addr_mem[r_wr_ptr] <= i_push_addr;
            r_data_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_sched.sv
// ============================================================================
// Module   : regfile_write_sched
// Purpose  : Merges WB and multiply/divide writes onto the single register-file
//            write port and stalls decode on pending MD destinations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_sched #(
    parameter  int DATA_W     = regfile_pkg::DATA_W,
    parameter  int ADDR_W     = regfile_pkg::ADDR_W,
    parameter  int FIFO_DEPTH = 2,
    localparam int NUM_REGS   = 2 ** ADDR_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                md_valid,
    output logic                md_ready,
    input  logic [ADDR_W-1:0]   md_addr,
    input  logic [DATA_W-1:0]   md_data,
    input  logic [ADDR_W-1:0]   dec_rs,
    input  logic [ADDR_W-1:0]   dec_rt,
    input  logic [ADDR_W-1:0]   dec_rd,
    input  logic                dec_rd_valid,
    input  logic                issue_md,
    output logic                stall,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_data,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    fifo_count
);

    import regfile_pkg::*;

    rf_src_e             w_src;
    logic                w_wb_wr;
    logic                w_md_acc;
    logic                w_md_nz;
    logic                w_push;
    logic                w_pop;
    logic                w_md_wr;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_stall;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic                r_rf_we;
    logic [ADDR_W-1:0]   r_rf_addr;
    logic [DATA_W-1:0]   r_rf_data;
    logic [NUM_REGS-1:0] r_busy;

    assign w_wb_wr  = wb_we & (wb_addr != '0);
    assign md_ready = ~w_fifo_full;
    assign w_md_acc = md_valid & md_ready;
    assign w_md_nz  = (md_addr != '0);

    always_comb begin
        w_src = SRC_NONE;
        if (w_wb_wr)                 w_src = SRC_WB;
        else if (!w_fifo_empty)      w_src = SRC_MD_FIFO;
        else if (w_md_acc && w_md_nz) w_src = SRC_MD_BYPASS;
    end

    assign w_pop   = (w_src == SRC_MD_FIFO);
    assign w_md_wr = (w_src == SRC_MD_FIFO) | (w_src == SRC_MD_BYPASS);
    // Accepted non-zero results go into the buffer unless they go straight out.
    assign w_push  = w_md_acc & w_md_nz & (w_src != SRC_MD_BYPASS);

    always_comb begin
        w_wr_addr = wb_addr;
        w_wr_data = wb_data;
        unique case (w_src)
            SRC_MD_FIFO: begin
                w_wr_addr = w_head_addr;
                w_wr_data = w_head_data;
            end
            SRC_MD_BYPASS: begin
                w_wr_addr = md_addr;
                w_wr_data = md_data;
            end
            default: ;
        endcase
    end

    md_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_md_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (md_addr),
        .i_push_data (md_data),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (fifo_count),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= (w_src != SRC_NONE);
            if (w_src != SRC_NONE) begin
                r_rf_addr <= w_wr_addr;
                r_rf_data <= w_wr_data;
            end
        end
    end

    assign w_stall = r_busy[dec_rs] | r_busy[dec_rt] | (dec_rd_valid & r_busy[dec_rd]);

    // Clear lands on the same edge the MD write reaches the port; a new issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_md_wr) w_busy_nxt[w_wr_addr] = 1'b0;
        if (issue_md && !w_stall && (dec_rd != '0)) w_busy_nxt[dec_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign stall   = w_stall;
    assign rf_we   = r_rf_we;
    assign rf_addr = r_rf_addr;
    assign rf_data = r_rf_data;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_sched.sv
// ============================================================================
// Module   : tb_regfile_write_sched
// Purpose  : Scenario bench for regfile_write_sched with an rf-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_sched;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wb_we, md_valid, md_ready, dec_rd_valid, issue_md, stall, rf_we;
    logic [ADDR_W-1:0]   wb_addr, md_addr, dec_rs, dec_rt, dec_rd, rf_addr;
    logic [DATA_W-1:0]   wb_data, md_data, rf_data;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    fifo_count;

    wr_t exp_q[$];
    wr_t mon_exp;
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    regfile_write_sched #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .md_valid     (md_valid),
        .md_ready     (md_ready),
        .md_addr      (md_addr),
        .md_data      (md_data),
        .dec_rs       (dec_rs),
        .dec_rt       (dec_rt),
        .dec_rd       (dec_rd),
        .dec_rd_valid (dec_rd_valid),
        .issue_md     (issue_md),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rf_unexpected: got write r%0d=%h, want no write", rf_addr, rf_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rf_addr, rf_data} !== {mon_exp.addr, mon_exp.data}) begin
                    n_err++;
                    $display("FAIL rf_order: got r%0d=%h, want r%0d=%h",
                             rf_addr, rf_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic idle();
        wb_we = 0; wb_addr = '0; wb_data = '0;
        md_valid = 0; md_addr = '0; md_data = '0;
        dec_rs = '0; dec_rt = '0; dec_rd = '0; dec_rd_valid = 0; issue_md = 0;
    endtask

    // Inputs change at posedge+1; checks happen at posedge+3.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rd);
        idle();
        issue_md = 1; dec_rd = rd; dec_rd_valid = 1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        dec_rs = 5; dec_rt = 6; dec_rd = 7; dec_rd_valid = 1;
        repeat (2) cyc();
        settle();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_cmp++; if (rf_addr !== '0) begin n_err++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
        n_cmp++; if (rf_data !== '0) begin n_err++; $display("FAIL reset_rf_data: got %h want 0", rf_data); end
        n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL reset_md_ready: got %b want 1", md_ready); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst_n = 1;
        idle();
        cyc();
    endtask

    task automatic test_wb_write();
        idle();
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        cyc();
        idle();
        settle();
        n_cmp++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL wb_write: got we=%b r%0d=%h want we=1 r5=deadbeef", rf_we, rf_addr, rf_data);
        end
        n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL wb_busy: got %h want 0", busy); end
        cyc();
    endtask

    task automatic test_bypass();
        idle();
        issue_md = 1; dec_rd = 8; dec_rd_valid = 1;
        settle();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL byp_issue_stall: got %b want 0", stall); end
        cyc();
        for (int c = 2; c <= 4; c++) begin
            idle();
            dec_rs = 8;
            if (c == 4) begin
                md_valid = 1; md_addr = 8; md_data = 32'h12;
                exp_q.push_back('{addr: 5'd8, data: 32'h12});
            end
            settle();
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL byp_stall_c%0d: got %b want 1", c, stall); end
            if (c == 4) begin
                n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL byp_ready: got %b want 1", md_ready); end
            end
            cyc();
        end
        idle();
        dec_rs = 8;
        settle();
        n_cmp++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd8, 32'h12}) begin
            n_err++;
            $display("FAIL byp_write: got we=%b r%0d=%h want we=1 r8=12", rf_we, rf_addr, rf_data);
        end
        n_cmp++; if (busy[8] !== 1'b0) begin n_err++; $display("FAIL byp_busy8: got %b want 0", busy[8]); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL byp_stall_c5: got %b want 1'b0", stall); end
        cyc();
    endtask

    task automatic test_wb_starve();
        logic [ADDR_W-1:0] md_a [3];
        logic [DATA_W-1:0] md_d [3];
        logic [ADDR_W-1:0] exp_a [4];
        int md_idx;
        md_a[0] = 3; md_a[1] = 4; md_a[2] = 6;
        md_d[0] = 32'h3333_0003; md_d[1] = 32'h4444_0004; md_d[2] = 32'h6666_0006;
        exp_a[0] = 16; exp_a[1] = 3; exp_a[2] = 4; exp_a[3] = 6;
        for (int i = 0; i < 3; i++) issue(md_a[i]);
        idle();
        settle();
        n_cmp++;
        if (busy !== 32'h0000_0058) begin n_err++; $display("FAIL starve_busy_set: got %h want 00000058", busy); end
        cyc();
        md_idx = 0;
        for (int b = 1; b <= 6; b++) begin
            idle();
            wb_we = 1; wb_addr = ADDR_W'(10 + b); wb_data = 32'hA000_0000 + 32'(b);
            exp_q.push_back('{addr: ADDR_W'(10 + b), data: 32'hA000_0000 + 32'(b)});
            if (md_idx < 3) begin
                md_valid = 1; md_addr = md_a[md_idx]; md_data = md_d[md_idx];
            end
            settle();
            n_cmp++;
            if (fifo_count !== CNT_W'((b == 1) ? 0 : (b == 2) ? 1 : 2)) begin
                n_err++;
                $display("FAIL starve_count_b%0d: got %0d", b, fifo_count);
            end
            n_cmp++;
            if (md_ready !== (b <= 2)) begin
                n_err++;
                $display("FAIL starve_ready_b%0d: got %b want %b", b, md_ready, (b <= 2));
            end
            if (md_valid && md_ready) md_idx++;
            cyc();
        end
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: md_a[i], data: md_d[i]});
        for (int d = 0; d <= 4; d++) begin
            idle();
            if (md_idx < 3) begin
                md_valid = 1; md_addr = md_a[md_idx]; md_data = md_d[md_idx];
            end
            settle();
            n_cmp++;
            if (d < 4) begin
                if ({rf_we, rf_addr} !== {1'b1, exp_a[d]}) begin
                    n_err++;
                    $display("FAIL drain_d%0d: got we=%b r%0d want we=1 r%0d", d, rf_we, rf_addr, exp_a[d]);
                end
            end else if (rf_we !== 1'b0) begin
                n_err++;
                $display("FAIL drain_d%0d: got we=%b want 0", d, rf_we);
            end
            if (md_valid && md_ready) md_idx++;
            cyc();
        end
        idle();
        settle();
        n_cmp++; if (md_idx != 3) begin n_err++; $display("FAIL starve_md_accepted: got %0d want 3", md_idx); end
        n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL starve_busy_clr: got %h want 0", busy); end
        n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL starve_count_end: got %0d want 0", fifo_count); end
        cyc();
    endtask

    task automatic test_r0();
        idle();
        wb_we = 1; wb_addr = 0; wb_data = 32'h5555_5555;
        md_valid = 1; md_addr = 0; md_data = 32'h6666_6666;
        issue_md = 1; dec_rd = 0; dec_rd_valid = 1;
        cyc();
        idle();
        wb_we = 1; wb_addr = 13; wb_data = 32'h1313_1313;
        md_valid = 1; md_addr = 0; md_data = 32'h7777_7777;
        exp_q.push_back('{addr: 5'd13, data: 32'h1313_1313});
        settle();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_rf_we: got %b want 0", rf_we); end
        n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL r0_count_a: got %0d want 0", fifo_count); end
        n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL r0_busy: got %h want 0", busy); end
        cyc();
        idle();
        settle();
        n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL r0_count_b: got %0d want 0", fifo_count); end
        cyc();
        settle();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_late_write: got %b want 0", rf_we); end
        cyc();
    endtask

    task automatic test_same_cycle();
        issue(9);
        idle();
        md_valid = 1; md_addr = 9; md_data = 32'h99;
        issue_md = 1; dec_rd = 9; dec_rd_valid = 0;
        exp_q.push_back('{addr: 5'd9, data: 32'h99});
        cyc();
        idle();
        dec_rs = 9;
        settle();
        n_cmp++; if (busy !== 32'h0000_0200) begin n_err++; $display("FAIL same_busy9: got %h want 00000200", busy); end
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL same_stall: got %b want 1", stall); end
        cyc();
        idle();
        md_valid = 1; md_addr = 9; md_data = 32'h9A;
        exp_q.push_back('{addr: 5'd9, data: 32'h9A});
        cyc();
        idle();
        settle();
        n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL same_busy_clr: got %h want 0", busy); end
        cyc();
    endtask

    task automatic test_reset_mid();
        issue(7);
        issue(11);
        issue(12);
        for (int i = 0; i < 2; i++) begin
            idle();
            wb_we = 1; wb_addr = ADDR_W'(20 + i); wb_data = 32'hB000_0000 + 32'(i);
            exp_q.push_back('{addr: ADDR_W'(20 + i), data: 32'hB000_0000 + 32'(i)});
            md_valid = 1; md_addr = ADDR_W'(11 + i); md_data = 32'hC000_0000 + 32'(i);
            cyc();
        end
        idle();
        wb_we = 1; wb_addr = 22; wb_data = 32'hB000_0002;
        settle();
        n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL rmid_count_pre: got %0d want 2", fifo_count); end
        n_cmp++; if (busy !== 32'h0000_1880) begin n_err++; $display("FAIL rmid_busy_pre: got %h want 00001880", busy); end
        n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL rmid_we_pre: got %b want 1", rf_we); end
        rst_n = 0;
        #1;
        exp_q.delete();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rmid_rf_we: got %b want 0", rf_we); end
        n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL rmid_busy: got %h want 0", busy); end
        n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
        idle();
        repeat (2) cyc();
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            settle();
            n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rmid_late_c%0d: got %b want 0", c, rf_we); end
        end
        cyc();
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_wb_write();
        test_bypass();
        test_wb_starve();
        test_r0();
        test_same_cycle();
        test_reset_mid();
        repeat (2) cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending writes want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler and scoreboard for the MIPS pipeline register file. It merges two write sources onto the register file's single write port:

- the in-order pipeline writeback (WB) stage;
- the multi-cycle multiply/divide unit (MD).

It buffers MD results while the WB stage holds the port. It also tracks destination registers with MD results still pending, and stalls decode on RAW/WAW hazards against them. It sits between the WB stage, the MD unit, decode, and the register file write inputs.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (NUM_REGS = 2**ADDR_W)
- FIFO_DEPTH, 2, MD result buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  WB write request; always accepted, never back-pressured
- wb_addr  in  ADDR_W  WB destination
- wb_data  in  DATA_W  WB data
- md_valid  in  1  MD result valid
- md_ready  out  1  scheduler can accept an MD result
- md_addr  in  ADDR_W  MD result destination
- md_data  in  DATA_W  MD result data
- dec_rs, dec_rt  in  ADDR_W  decode source registers
- dec_rd  in  ADDR_W  decode destination register
- dec_rd_valid  in  1  decode instruction writes dec_rd
- issue_md  in  1  decode issues an MD op this cycle to dec_rd
- stall  out  1  decode hazard stall
- rf_we, rf_addr, rf_data  out  1/ADDR_W/DATA_W  register-file write port, registered
- busy  out  NUM_REGS  scoreboard bit vector
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered MD results

## Operation
- Writes to address 0 are dropped:
  - WB with wb_addr=0 is treated as wb_we=0.
  - An accepted MD result with md_addr=0 is discarded and never buffered.
  - busy[0] is hard-wired 0.
- Port priority:
  - WB (wb_we & wb_addr≠0) always owns the next rf write.
  - Otherwise the FIFO head is popped.
  - Otherwise, if the FIFO is empty, an MD result accepted this cycle bypasses the FIFO directly to the port.
  - Otherwise rf_we=0.
- md_ready = (fifo_count < FIFO_DEPTH). It is combinational from the count and does not account for a same-cycle pop.
- An MD result is accepted on md_valid & md_ready. It is pushed unless it is bypassed or discarded.
- FIFO order is strict FIFO. A push and a pop in the same cycle are legal; the count is unchanged.
- Scoreboard:
  - Set: busy[dec_rd] is set on issue_md & ~stall & dec_rd≠0.
  - Clear: busy[a] is cleared on the cycle the MD result for a is driven onto rf (rf_we=1 from the MD source).
  - A set and a clear of the same register in the same cycle: set wins.
  - An accepted MD result for a=0, or for a register whose busy bit is clear, is a protocol error. Such a result is still written, and the bit stays clear.
- stall (combinational) = busy[dec_rs] | busy[dec_rt] | (dec_rd_valid & busy[dec_rd]).
- issue_md while stall=1 is ignored.

## Timing
- Reset values:
  - rf_we=0, rf_addr=0, rf_data=0.
  - busy=0, fifo_count=0, FIFO empty.
  - md_ready=1 and stall=0 while in reset.
- Latency:
  - WB request in cycle N appears on rf_* in cycle N+1 (valid through the clk-high phase, when the register file writes).
  - Bypassed MD result accepted in N appears in N+1.
  - Buffered MD result appears at the first cycle after N with no WB write, at the earliest N+2.
- busy changes take effect the cycle after the set/clear edge. stall reflects the updated vector that same cycle.
- An MD result clearing busy[x] in cycle N+1 (rf write) lets decode stop stalling on x in cycle N+1.
- Continuous WB traffic starves the FIFO indefinitely. The MD unit sees md_ready=0 once the FIFO is full; this is the required behaviour.
- Reset asserted mid-operation clears all state asynchronously. Buffered results and pending busy bits are lost, and rf_we drops immediately.

## Structure
- Shared package regfile_pkg:
  - constants DATA_W, ADDR_W, NUM_REGS;
  - typedef rf_wr_t {we, addr, data};
  - enum rf_src_e {SRC_NONE, SRC_WB, SRC_MD_FIFO, SRC_MD_BYPASS}.
- Sub-module md_result_fifo:
  - parameterised depth;
  - push/pop/full/empty/count;
  - head {addr, data};
  - asynchronous active-low reset.
- Top level contains the priority mux, the rf output registers, the scoreboard, and the stall logic.

## Test plan
- Reset, then WB write r5=0xDEADBEEF in cycle 1 → cycle 2: rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; busy=0.
- issue_md to r8, then MD result r8=0x12 in cycle 4 with WB idle → bypass; rf write r8=0x12 in cycle 5; busy[8] 1→0 at cycle 5; stall with dec_rs=8 high in cycles 2–4, low in cycle 5.
- WB writes every cycle for 6 cycles while MD returns r3, r4, r6 (all issued earlier) → r3 and r4 buffered; md_ready=0 with fifo_count=2; r6 held by the MD unit; after WB stops, rf writes r3, r4, r6 in consecutive cycles, in order.
- wb_we to r0 and MD result to r0 → rf_we stays 0; fifo_count unchanged; busy[0]=0.
- Same-cycle clear of r9 (MD result written) and issue_md to r9 → busy[9]=1 next cycle.
- rst_n pulled low with 2 buffered results and busy[7]=1 → rf_we=0 immediately; busy=0; fifo_count=0; no later rf write of the buffered data.
